// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit processor front end: opcodes, ALU encodings,
// instruction field positions and the fetch/decode FSM state type.
package cpu_pkg;

    localparam int REG_ADDR_W = 3;
    localparam int DATA_W     = 8;
    localparam int INSTR_W    = 32;

    localparam int OPC_LO  = 24;
    localparam int DST_LO  = 16;
    localparam int SRC1_LO = 8;
    localparam int SRC2_LO = 0;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_HALT  = 8'hFF;

    typedef enum logic [2:0] {
        ALU_FWD = 3'b000,
        ALU_ADD = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011
    } aluop_t;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_HALT   = 3'd4
    } state_t;

endpackage

// File: rtl/pc_counter.sv
// Program counter register: loads RESET_VAL on active-low sync reset and
// advances by STEP (wrapping) when inc is high.
module pc_counter #(
    parameter int                WIDTH     = 32,
    parameter int unsigned       STEP      = 4,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] pc
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= RESET_VAL;
        end else if (inc) begin
            pc <= pc + STEP_W;
        end
    end

endmodule

// File: rtl/instr_decode_ctrl.sv
// Multi-cycle fetch/decode/exec/write-back controller feeding reg_file and the ALU.
// Optional HALT opcode (0xFF) and HALTED output enabled by INSTR_DECODE_HALT_EN.
module instr_decode_ctrl
    import cpu_pkg::*;
#(
    parameter int                   PC_WIDTH = 32,
    parameter int unsigned          PC_STEP  = 4,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
    input  logic                  CLK,
    input  logic                  RESET,
    output logic [PC_WIDTH-1:0]   INSTR_ADDR,
    output logic                  INSTR_REQ,
    input  logic                  INSTR_VALID,
    input  logic [INSTR_W-1:0]    INSTRUCTION,
    output logic [REG_ADDR_W-1:0] READREG1,
    output logic [REG_ADDR_W-1:0] READREG2,
    output logic [2:0]            ALUOP,
    output logic [DATA_W-1:0]     IMMEDIATE,
    output logic                  IMM_SEL,
    output logic                  NEG_SEL,
    input  logic [DATA_W-1:0]     ALURESULT,
    output logic [REG_ADDR_W-1:0] WRITEREG,
    output logic [DATA_W-1:0]     WRITEDATA,
    output logic                  WRITEENABLE,
    output logic                  ILLEGAL
`ifdef INSTR_DECODE_HALT_EN
    ,
    output logic                  HALTED
`endif
);

    state_t             state;
    state_t             state_nxt;
    logic [INSTR_W-1:0] ir;
    logic               wr_pend;
    logic               we_r;
    logic               pc_inc;

    aluop_t             dec_aluop;
    logic               dec_imm;
    logic               dec_neg;
    logic               dec_write;
    logic               dec_illegal;
    logic [7:0]         opcode;

`ifdef INSTR_DECODE_HALT_EN
    logic               dec_halt;
    logic               halt_pend;
`endif

    // Upper register-address bits are architecturally ignored.
    logic               unused_ir_bits;
    assign unused_ir_bits = ^{ir[DST_LO+7:DST_LO+REG_ADDR_W], ir[SRC1_LO+7:SRC1_LO+REG_ADDR_W]};

    assign opcode = ir[OPC_LO+:8];

    pc_counter #(
        .WIDTH     (PC_WIDTH),
        .STEP      (PC_STEP),
        .RESET_VAL (RESET_PC)
    ) u_pc (
        .clk   (CLK),
        .rst_n (RESET),
        .inc   (pc_inc),
        .pc    (INSTR_ADDR)
    );

    always_comb begin
        dec_aluop   = ALU_FWD;
        dec_imm     = 1'b0;
        dec_neg     = 1'b0;
        dec_write   = 1'b1;
        dec_illegal = 1'b0;
`ifdef INSTR_DECODE_HALT_EN
        dec_halt    = 1'b0;
`endif
        case (opcode)
            OP_LOADI: dec_imm = 1'b1;
            OP_MOV:   dec_aluop = ALU_FWD;
            OP_ADD:   dec_aluop = ALU_ADD;
            OP_SUB: begin
                dec_aluop = ALU_ADD;
                dec_neg   = 1'b1;
            end
            OP_AND:   dec_aluop = ALU_AND;
            OP_OR:    dec_aluop = ALU_OR;
`ifdef INSTR_DECODE_HALT_EN
            OP_HALT: begin
                dec_write = 1'b0;
                dec_halt  = 1'b1;
            end
`endif
            default: begin
                dec_write   = 1'b0;
                dec_illegal = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state     <= S_FETCH;
            ir        <= '0;
            READREG1  <= '0;
            READREG2  <= '0;
            ALUOP     <= '0;
            IMMEDIATE <= '0;
            IMM_SEL   <= 1'b0;
            NEG_SEL   <= 1'b0;
            WRITEREG  <= '0;
            WRITEDATA <= '0;
            ILLEGAL   <= 1'b0;
            wr_pend   <= 1'b0;
            we_r      <= 1'b0;
`ifdef INSTR_DECODE_HALT_EN
            halt_pend <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (state == S_FETCH && INSTR_VALID) begin
                ir <= INSTRUCTION;
            end
            // Decode results hold until the next instruction is decoded.
            if (state == S_DECODE) begin
                READREG1  <= ir[SRC1_LO+:REG_ADDR_W];
                READREG2  <= ir[SRC2_LO+:REG_ADDR_W];
                WRITEREG  <= ir[DST_LO+:REG_ADDR_W];
                IMMEDIATE <= ir[SRC2_LO+:DATA_W];
                ALUOP     <= dec_aluop;
                IMM_SEL   <= dec_imm;
                NEG_SEL   <= dec_neg;
                wr_pend   <= dec_write;
`ifdef INSTR_DECODE_HALT_EN
                halt_pend <= dec_halt;
`endif
                if (dec_illegal) begin
                    ILLEGAL <= 1'b1;
                end
            end
            if (state == S_EXEC) begin
                WRITEDATA <= ALURESULT;
            end
            we_r <= (state == S_EXEC) && wr_pend;
        end
    end

    always_comb begin
        state_nxt   = state;
        INSTR_REQ   = 1'b0;
        pc_inc      = 1'b0;
        // Gating with RESET drops a write whose cycle coincides with reset.
        WRITEENABLE = we_r && RESET;
`ifdef INSTR_DECODE_HALT_EN
        HALTED      = (state == S_HALT);
`endif
        case (state)
            S_FETCH: begin
                INSTR_REQ = RESET;
                if (INSTR_VALID) begin
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC:   state_nxt = S_WB;
            S_WB: begin
                pc_inc    = 1'b1;
`ifdef INSTR_DECODE_HALT_EN
                state_nxt = halt_pend ? S_HALT : S_FETCH;
`else
                state_nxt = S_FETCH;
`endif
            end
`ifdef INSTR_DECODE_HALT_EN
            S_HALT:   state_nxt = S_HALT;
`endif
            default:  state_nxt = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_instr_decode_ctrl.sv
// Directed bench for instr_decode_ctrl with an ALU/reg_file environment model
// and a write-back scoreboard; a second instance checks PC wrap-around.
module tb_instr_decode_ctrl;

    logic        clk = 1'b0;
    logic        RESET = 1'b0;
    logic        INSTR_VALID = 1'b0;
    logic [31:0] INSTRUCTION = '0;
    logic [7:0]  ALURESULT;
    logic [31:0] INSTR_ADDR;
    logic        INSTR_REQ;
    logic [2:0]  READREG1, READREG2, ALUOP, WRITEREG;
    logic [7:0]  IMMEDIATE, WRITEDATA;
    logic        IMM_SEL, NEG_SEL, WRITEENABLE, ILLEGAL;
`ifdef INSTR_DECODE_HALT_EN
    logic        HALTED;
    logic        w_unused_halted;
`endif

    logic [31:0] w_addr;
    logic        w_req;
    logic [2:0]  w_unused_rr1, w_unused_rr2, w_unused_aluop, w_unused_wreg;
    logic [7:0]  w_unused_imm, w_unused_wdata;
    logic        w_unused_isel, w_unused_nsel, w_unused_we, w_unused_ill;
    logic [7:0]  w_alu = 8'h00;

    typedef struct packed {
        logic [2:0] r;
        logic [7:0] d;
    } wb_t;
    wb_t sb[$];

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_pc = 32'h0;
    logic [7:0]  ref_r [8];
    logic [7:0]  bregs [8];

    always #5 clk = ~clk;

    instr_decode_ctrl u_dut (
        .CLK(clk), .RESET(RESET), .INSTR_ADDR(INSTR_ADDR), .INSTR_REQ(INSTR_REQ),
        .INSTR_VALID(INSTR_VALID), .INSTRUCTION(INSTRUCTION),
        .READREG1(READREG1), .READREG2(READREG2), .ALUOP(ALUOP),
        .IMMEDIATE(IMMEDIATE), .IMM_SEL(IMM_SEL), .NEG_SEL(NEG_SEL),
        .ALURESULT(ALURESULT), .WRITEREG(WRITEREG), .WRITEDATA(WRITEDATA),
        .WRITEENABLE(WRITEENABLE), .ILLEGAL(ILLEGAL)
`ifdef INSTR_DECODE_HALT_EN
        , .HALTED(HALTED)
`endif
    );

    instr_decode_ctrl #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .CLK(clk), .RESET(RESET), .INSTR_ADDR(w_addr), .INSTR_REQ(w_req),
        .INSTR_VALID(INSTR_VALID), .INSTRUCTION(INSTRUCTION),
        .READREG1(w_unused_rr1), .READREG2(w_unused_rr2), .ALUOP(w_unused_aluop),
        .IMMEDIATE(w_unused_imm), .IMM_SEL(w_unused_isel), .NEG_SEL(w_unused_nsel),
        .ALURESULT(w_alu), .WRITEREG(w_unused_wreg), .WRITEDATA(w_unused_wdata),
        .WRITEENABLE(w_unused_we), .ILLEGAL(w_unused_ill)
`ifdef INSTR_DECODE_HALT_EN
        , .HALTED(w_unused_halted)
`endif
    );

    // reg_file + ALU environment driven by the controller's outputs
    initial for (int i = 0; i < 8; i++) begin bregs[i] = 8'h00; ref_r[i] = 8'h00; end

    always @(posedge clk) if (WRITEENABLE) bregs[WRITEREG] <= WRITEDATA;

    always_comb begin
        logic [7:0] b;
        b = IMM_SEL ? IMMEDIATE : bregs[READREG2];
        if (NEG_SEL) b = -b;
        case (ALUOP)
            3'b001:  ALURESULT = bregs[READREG1] + b;
            3'b010:  ALURESULT = bregs[READREG1] & b;
            3'b011:  ALURESULT = bregs[READREG1] | b;
            default: ALURESULT = b;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (WRITEENABLE === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_we", 32'(WRITEREG), 32'hDEAD);
            end else begin
                wb_t e;
                e = sb.pop_front();
                chk("wb_reg", 32'(WRITEREG), 32'(e.r));
                chk("wb_data", 32'(WRITEDATA), 32'(e.d));
            end
        end
    end

    function automatic bit is_legal(input logic [7:0] opc);
        return opc <= 8'h05;
    endfunction

    function automatic logic [7:0] exp_data(input logic [31:0] ins);
        logic [7:0] a, b;
        a = ref_r[ins[10:8]];
        b = ref_r[ins[2:0]];
        case (ins[31:24])
            8'h00:   return ins[7:0];
            8'h01:   return b;
            8'h02:   return a + b;
            8'h03:   return a - b;
            8'h04:   return a & b;
            default: return a | b;
        endcase
    endfunction

    task automatic issue(input logic [31:0] ins, input bit rst_in_wb, input bit is_halt);
        int  guard;
        bit  legal;
        wb_t e;
        legal = is_legal(ins[31:24]);
        guard = 0;
        @(negedge clk);
        while (INSTR_REQ !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("req_wait", 32'(INSTR_REQ), 32'h1);
        chk("pc_fetch", INSTR_ADDR, exp_pc);
        INSTRUCTION = ins;
        INSTR_VALID = 1'b1;
        if (legal && !rst_in_wb) begin
            e.r = ins[18:16];
            e.d = exp_data(ins);
            sb.push_back(e);
            ref_r[ins[18:16]] = e.d;
        end
        @(posedge clk); #1;
        // decode cycle: garbage with VALID high must be ignored
        INSTRUCTION = $urandom;
        @(negedge clk);
        chk("dec_req", 32'(INSTR_REQ), 32'h0);
        chk("dec_we", 32'(WRITEENABLE), 32'h0);
        @(posedge clk); #1;
        INSTRUCTION = $urandom;
        @(negedge clk);
        if (legal) begin
            chk("rr1", 32'(READREG1), 32'(ins[10:8]));
            chk("rr2", 32'(READREG2), 32'(ins[2:0]));
            chk("imm", 32'(IMMEDIATE), 32'(ins[7:0]));
            chk("aluop", 32'(ALUOP), (ins[31:24] == 8'h02 || ins[31:24] == 8'h03) ? 32'h1 :
                                     (ins[31:24] == 8'h04) ? 32'h2 :
                                     (ins[31:24] == 8'h05) ? 32'h3 : 32'h0);
            chk("imm_sel", 32'(IMM_SEL), 32'(ins[31:24] == 8'h00));
            chk("neg_sel", 32'(NEG_SEL), 32'(ins[31:24] == 8'h03));
        end
        @(posedge clk); #1;
        INSTR_VALID = 1'b0;
        if (rst_in_wb) RESET = 1'b0;
        @(negedge clk);
        chk("wb_we", 32'(WRITEENABLE), 32'(legal && !rst_in_wb));
        exp_pc = rst_in_wb ? 32'h0 : exp_pc + 32'd4;
        @(posedge clk); #1;
        @(negedge clk);
        if (rst_in_wb) begin
            chk("rst_req", 32'(INSTR_REQ), 32'h0);
            chk("rst_we", 32'(WRITEENABLE), 32'h0);
            chk("rst_pc", INSTR_ADDR, 32'h0);
            chk("rst_ill", 32'(ILLEGAL), 32'h0);
            chk("rst_wdata", 32'(WRITEDATA), 32'h0);
            @(posedge clk); #1;
            RESET = 1'b1;
            @(negedge clk);
            chk("rel_req", 32'(INSTR_REQ), 32'h1);
            chk("rel_pc", INSTR_ADDR, 32'h0);
        end else if (is_halt) begin
            chk("halt_req", 32'(INSTR_REQ), 32'h0);
        end else begin
            chk("next_req", 32'(INSTR_REQ), 32'h1);
            chk("next_pc", INSTR_ADDR, exp_pc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        RESET = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_req", 32'(INSTR_REQ), 32'h0);
        chk("reset_pc", INSTR_ADDR, 32'h0);
        chk("reset_outs", {READREG1, READREG2, ALUOP, WRITEREG, IMM_SEL, NEG_SEL, WRITEENABLE, ILLEGAL},
            32'h0);
        chk("reset_bytes", {16'h0, IMMEDIATE, WRITEDATA}, 32'h0);
        chk("wrap_reset_pc", w_addr, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        RESET = 1'b1;

        issue(32'h00_02_00_2A, 1'b0, 1'b0);
        chk("wrap_pc", w_addr, 32'h0);
        chk("wrap_req", 32'(w_req), 32'h1);
        issue(32'h00_01_00_05, 1'b0, 1'b0);
        issue(32'h02_03_02_01, 1'b0, 1'b0);
        issue(32'h03_04_02_01, 1'b0, 1'b0);

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_req", 32'(INSTR_REQ), 32'h1);
            chk("idle_pc", INSTR_ADDR, exp_pc);
        end

        issue(32'h04_06_02_01, 1'b0, 1'b0);
        issue(32'h05_07_02_01, 1'b0, 1'b0);
        issue(32'h01_00_00_03, 1'b0, 1'b0);
        issue(32'h02_FD_FA_F9, 1'b0, 1'b0);
        chk("ill_before", 32'(ILLEGAL), 32'h0);
        issue(32'h07_01_02_03, 1'b0, 1'b0);
        chk("ill_set", 32'(ILLEGAL), 32'h1);
`ifndef INSTR_DECODE_HALT_EN
        issue(32'hFF_00_00_00, 1'b0, 1'b0);
        chk("ill_ff", 32'(ILLEGAL), 32'h1);
`endif
        issue(32'h00_06_00_77, 1'b1, 1'b0);
        issue(32'h00_05_00_3C, 1'b0, 1'b0);

`ifdef INSTR_DECODE_HALT_EN
        issue(32'hFF_00_00_00, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("halted", 32'(HALTED), 32'h1);
            chk("halt_req_hold", 32'(INSTR_REQ), 32'h0);
            chk("halt_pc", INSTR_ADDR, exp_pc);
        end
        @(posedge clk); #1;
        RESET = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        RESET = 1'b1;
        exp_pc = 32'h0;
        @(negedge clk);
        chk("halt_cleared", 32'(HALTED), 32'h0);
        chk("halt_rel_req", 32'(INSTR_REQ), 32'h1);
        chk("halt_rel_pc", INSTR_ADDR, 32'h0);
`endif

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'h0);
        chk("rf_r3", 32'(bregs[3]), 32'h2F);
        chk("rf_r4", 32'(bregs[4]), 32'h25);
        chk("rf_r6_dropped", 32'(bregs[6]), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_decode_ctrl.md
Name: instr_decode_ctrl

Overview:
- Multi-cycle fetch/decode/control stage directly upstream of reg_file in the 8-bit processor.
- Holds the PC and requests 32-bit instructions from instruction memory with a valid handshake.
- Decodes each instruction and drives reg_file read addresses, ALU controls, and a one-cycle write-back (WRITEREG, WRITEDATA, WRITEENABLE).

Parameters:
- PC_WIDTH, 32, width of program counter and INSTR_ADDR.
- PC_STEP, 4, PC increment per retired instruction.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- CLK  in  1  single clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-low reset (0 = reset asserted at next rising CLK edge).
- INSTR_ADDR  out  PC_WIDTH  current PC.
- INSTR_REQ  out  1  fetch request, high only in S_FETCH.
- INSTR_VALID  in  1  instruction memory data valid.
- INSTRUCTION  in  32  [31:24] opcode, [23:16] dest reg (bits 2:0 used), [15:8] src1 reg, [7:0] src2 reg or immediate.
- READREG1  out  3  reg_file read address 1 (src1[2:0]).
- READREG2  out  3  reg_file read address 2 (src2[2:0]).
- ALUOP  out  3  000 FWD, 001 ADD, 010 AND, 011 OR.
- IMMEDIATE  out  8  src2 byte.
- IMM_SEL  out  1  1 = ALU operand B from IMMEDIATE.
- NEG_SEL  out  1  1 = ALU operand B two's-complemented (SUB).
- ALURESULT  in  8  combinational ALU result.
- WRITEREG  out  3  reg_file write address.
- WRITEDATA  out  8  reg_file write data.
- WRITEENABLE  out  1  reg_file write strobe, one cycle per write.
- ILLEGAL  out  1  sticky: unknown opcode seen.

Behaviour:
- Opcodes:
  - 0x00 LOADI: FWD, IMM_SEL=1.
  - 0x01 MOV: FWD, reg.
  - 0x02 ADD.
  - 0x03 SUB: ADD with NEG_SEL=1.
  - 0x04 AND.
  - 0x05 OR.
- FSM states: S_FETCH → S_DECODE → S_EXEC → S_WB → S_FETCH.
- S_FETCH:
  - INSTR_REQ=1 and INSTR_ADDR=PC.
  - Stays in S_FETCH while INSTR_VALID=0.
  - On INSTR_VALID=1: latch INSTRUCTION into IR, go to S_DECODE.
- S_DECODE: register READREG1/2, ALUOP, IMMEDIATE, IMM_SEL, NEG_SEL from IR. These hold until the next decode.
- S_EXEC: one settle cycle for reg_file read + ALU; ALURESULT is sampled at the end of this cycle into WRITEDATA.
- S_WB:
  - WRITEENABLE=1 for exactly this cycle with WRITEREG=dest[2:0]; reg_file writes on this cycle's edge.
  - PC <= PC+PC_STEP, wrapping modulo 2^PC_WIDTH.
- Latency: valid accepted at cycle N; WRITEENABLE high in cycle N+3; next INSTR_REQ in cycle N+4 with the new PC.
- Illegal opcode:
  - No WRITEENABLE in S_WB.
  - ILLEGAL set and held until reset.
  - PC still advances.
- Unused register-address bits [7:3] are ignored.
- Reset (RESET=0 at an edge, any state, including mid-S_WB):
  - State → S_FETCH, PC → RESET_PC, IR → 0.
  - All outputs → 0: READREG1/2, WRITEREG, WRITEDATA, ALUOP, IMMEDIATE, IMM_SEL, NEG_SEL, WRITEENABLE, ILLEGAL.
  - INSTR_REQ held 0 while RESET=0.
  - An in-flight write is dropped.
- INSTR_VALID outside S_FETCH is ignored.
- INSTRUCTION is sampled only on the accepting edge.

Optional Feature:
- Macro INSTR_DECODE_HALT_EN.
- Defined:
  - Opcode 0xFF is HALT. After its S_WB (no write), the FSM enters S_HALT.
  - In S_HALT: INSTR_REQ=0, PC frozen, new output HALTED=1.
  - Only reset leaves S_HALT.
- Undefined: no HALTED port; 0xFF is illegal (sets ILLEGAL).

Decomposition:
- Package cpu_pkg holds:
  - Opcode constants.
  - ALUOP encodings.
  - FSM state typedef.
  - Field bit positions.
  - REG_ADDR_W=3, DATA_W=8.
- One sub-module, pc_counter: parameterised PC register with load-reset and increment enable, instantiated once.

Test Plan:
- Reset then LOADI 0x00_02_00_2A with INSTR_VALID immediate → in cycle N+3: WRITEENABLE=1, WRITEREG=2, WRITEDATA=0x2A; then PC=4.
- ADD 0x02_03_02_01 with ALU model (r2=0x2A, r1=0x05) → READREG1=2, READREG2=1, ALUOP=001, WRITEDATA=0x2F to r3.
- SUB 0x03_04_02_01 → NEG_SEL=1, WRITEDATA=0x25. Then INSTR_VALID held low 5 cycles in S_FETCH → INSTR_REQ stays 1, no WRITEENABLE, PC unchanged.
- Opcode 0x07 → ILLEGAL=1, no WRITEENABLE, PC advances 4. Then PC from 0xFFFFFFFC wraps to 0.
- RESET=0 during the S_WB cycle → next cycle WRITEENABLE=0, PC=RESET_PC, ILLEGAL=0. INSTR_REQ=1 in the first cycle after RESET returns high.
- With INSTR_DECODE_HALT_EN: 0xFF000000 → HALTED=1, INSTR_REQ=0 for 10 cycles; reset clears it.
